pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 16-bit 5-stage core (IF/REG/EX/MEM/WB).
//  Detects load-use hazards, taken branches (resolved in EX), jumps (resolved in REG) and
//  data-memory wait states. Drives PC/IF-REG stalls plus REG_Mask/EX_Mask/MEM_Mask; mask=1
//  zeroes that stage's EX/MEM/WB control bits (bubble). Sits beside the control decoder.
// PARAMETERS
//  REG_ADDR_W   4   register-address width
//  MEM_TIMEOUT  15  max MEM_WAIT cycles before mem_timeout; 1..255
// PORTS
//  clk           in   1           system clock, rising edge
//  reset         in   1           asynchronous, active-low (0 = in reset)
//  id_rs1        in   REG_ADDR_W  REG-stage source reg 1
//  id_rs2        in   REG_ADDR_W  REG-stage source reg 2
//  id_use_rs1    in   1           REG-stage instr reads rs1
//  id_use_rs2    in   1           REG-stage instr reads rs2
//  id_jump       in   1           REG-stage instr is jump (JTarget valid)
//  ex_rd         in   REG_ADDR_W  EX-stage dest reg
//  ex_is_load    in   1           EX-stage instr is load
//  ex_branch_tkn in   1           EX-stage branch resolved taken
//  mem_req       in   1           MEM-stage data memory access
//  mem_ready     in   1           data memory done (same-cycle completion allowed)
//  pc_stall      out  1           hold PC
//  ifreg_stall   out  1           hold IF/REG pipeline register
//  REG_Mask      out  1           squash instr in REG (IF/REG)
//  EX_Mask       out  1           bubble into EX (REG/EX)
//  MEM_Mask      out  1           bubble into MEM (EX/MEM)
//  mem_timeout   out  1           sticky: memory exceeded MEM_TIMEOUT
//  state         out  3           current FSM state (debug)
// BEHAVIOUR
//  States: INIT=0, RUN=1, LU_STALL=2, BR_FLUSH=3, MEM_WAIT=4. All outputs registered.
//  Reset (reset=0): state=INIT, pc_stall=1, ifreg_stall=1, all masks=1, mem_timeout=0, cnt=0.
//  INIT: one cycle, all masks=1, stalls=1 -> RUN.
//  Events evaluated each cycle in RUN, priority high->low:
//   1 mem_req & ~mem_ready: -> MEM_WAIT; pc_stall=ifreg_stall=1, MEM_Mask=1; EX/REG masks
//     hold 0 (upstream frozen, not squashed).
//   2 ex_branch_tkn: -> BR_FLUSH; REG_Mask=1, EX_Mask=1 next cycle (kills 2 younger instrs).
//     Overrides concurrent load-use/jump (younger instrs are wrong path).
//   3 load-use: ex_is_load & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)):
//     -> LU_STALL; pc_stall=ifreg_stall=1, EX_Mask=1 for exactly 1 cycle. ex_rd==0 counts.
//   4 id_jump (no hazard): stay RUN; REG_Mask=1 next cycle only (kills 1 fetched instr).
//     Jump with load-use stalls first; REG_Mask issued when jump advances.
//  LU_STALL: 1 cycle -> RUN, stalls released, EX_Mask=0.
//  BR_FLUSH: 1 cycle, masks cleared -> RUN. New branch here is ignored (it is squashed).
//  MEM_WAIT: cnt increments from 1 each cycle; mem_ready=1 -> RUN, stalls/MEM_Mask drop next
//   cycle, cnt=0. cnt==MEM_TIMEOUT without ready -> mem_timeout=1 (sticky), -> RUN anyway.
//   Branch/load-use inputs ignored during MEM_WAIT; re-evaluated on return to RUN.
//  cnt saturates, 8 bits; no wrap. Reset mid-operation: async return to reset values.
// STRUCTURE
//  Shared package hazard_pkg: state encodings (INIT..MEM_WAIT), STATE_W=3.
//  One sub-module natural: hazard_cmp (combinational load-use comparator, REG_ADDR_W param).
//  FSM, masks, counter in this module; no other submodules.
// TESTING
//  Reset: reset=0 10ns -> masks=1, stalls=1, state=0; release -> 1 cycle INIT then state=1.
//  Load-use: ex_is_load=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> 1 cycle pc_stall=1, EX_Mask=1.
//  Branch+load-use same cycle: ex_branch_tkn=1 plus hazard -> state=3, REG_Mask=EX_Mask=1,
//   no stall.
//  Jump: id_jump=1 alone -> REG_Mask=1 one cycle, pc_stall=0.
//  Mem wait: mem_req=1, mem_ready=0 3 cycles then 1 -> stalls=1 3 cycles, MEM_Mask=1, RUN after.
//  Timeout: MEM_TIMEOUT=15, mem_ready=0 forever -> mem_timeout=1 after cycle 15, stays till reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// the bundle of stall/mask control bits and the counter width.
package hazard_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_LU_STALL = 3'd2,
        ST_BR_FLUSH = 3'd3,
        ST_MEM_WAIT = 3'd4
    } state_e;

    // Stall and squash controls that leave the block as one registered group.
    typedef struct packed {
        logic pc_stall;
        logic ifreg_stall;
        logic reg_mask;
        logic ex_mask;
        logic mem_mask;
    } ctrl_t;

    // Everything held and squashed: used while the pipeline comes out of reset.
    localparam ctrl_t CTRL_ALL  = 5'b11111;
    // Free-running pipeline, no bubbles.
    localparam ctrl_t CTRL_NONE = 5'b00000;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave): hazard sources in, stalls/masks/debug state out.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4
);
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  id_jump;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_is_load;
    logic                  ex_branch_tkn;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_stall;
    logic                  ifreg_stall;
    logic                  REG_Mask;
    logic                  EX_Mask;
    logic                  MEM_Mask;
    logic                  mem_timeout;
    logic [STATE_W-1:0]    state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_jump,
        output ex_rd, ex_is_load, ex_branch_tkn, mem_req, mem_ready,
        input  pc_stall, ifreg_stall, REG_Mask, EX_Mask, MEM_Mask, mem_timeout, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_jump,
        input  ex_rd, ex_is_load, ex_branch_tkn, mem_req, mem_ready,
        output pc_stall, ifreg_stall, REG_Mask, EX_Mask, MEM_Mask, mem_timeout, state
    );

endinterface

// File: rtl/hazard_cmp.sv
// Combinational load-use detector: the REG-stage instruction reads a register
// that the load currently in EX will write. Register 0 is not special-cased.
module hazard_cmp #(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_is_load_i,
    output logic                  load_use_o
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Compare each used source operand against the load's destination.
    always_comb begin
        rs1_hit_s  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
        rs2_hit_s  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
        load_use_o = ex_is_load_i & (rs1_hit_s | rs2_hit_s);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core. A small FSM arbitrates
// memory wait states, taken branches, load-use hazards and jumps, and drives
// registered PC/IF-REG stalls plus the per-stage bubble masks.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_e           state_q;
    state_e           state_d;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             load_use_s;
    logic             mem_stall_s;

    hazard_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .id_use_rs1_i (bus.id_use_rs1),
        .id_use_rs2_i (bus.id_use_rs2),
        .ex_rd_i      (bus.ex_rd),
        .ex_is_load_i (bus.ex_is_load),
        .load_use_o   (load_use_s)
    );

    assign mem_stall_s = bus.mem_req & ~bus.mem_ready;

    // Next state, next control bundle, wait counter and sticky timeout flag.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = CTRL_NONE;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall_s) begin
                    // Upstream is frozen, not squashed: only MEM gets a bubble.
                    state_d            = ST_MEM_WAIT;
                    ctrl_d.pc_stall    = 1'b1;
                    ctrl_d.ifreg_stall = 1'b1;
                    ctrl_d.mem_mask    = 1'b1;
                    cnt_d              = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (bus.ex_branch_tkn) begin
                    // Younger instructions are wrong-path, so any hazard they
                    // carry is irrelevant.
                    state_d         = ST_BR_FLUSH;
                    ctrl_d.reg_mask = 1'b1;
                    ctrl_d.ex_mask  = 1'b1;
                end else if (load_use_s) begin
                    state_d            = ST_LU_STALL;
                    ctrl_d.pc_stall    = 1'b1;
                    ctrl_d.ifreg_stall = 1'b1;
                    ctrl_d.ex_mask     = 1'b1;
                end else if (bus.id_jump) begin
                    ctrl_d.reg_mask = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LU_STALL: begin
                // A jump held behind the stall kills its fetched successor now.
                state_d         = ST_RUN;
                ctrl_d.reg_mask = bus.id_jump;
            end
            ST_BR_FLUSH: begin
                state_d = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q >= CNT_LIMIT) begin
                    state_d   = ST_RUN;
                    cnt_d     = {CNT_W{1'b0}};
                    timeout_d = 1'b1;
                end else begin
                    ctrl_d.pc_stall    = 1'b1;
                    ctrl_d.ifreg_stall = 1'b1;
                    ctrl_d.mem_mask    = 1'b1;
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1});
                end
            end
            default: begin
                state_d = ST_INIT;
                ctrl_d  = CTRL_ALL;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, controls, counter and timeout registers with async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            ctrl_q    <= CTRL_ALL;
            cnt_q     <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_stall    = ctrl_q.pc_stall;
    assign bus.ifreg_stall = ctrl_q.ifreg_stall;
    assign bus.REG_Mask    = ctrl_q.reg_mask;
    assign bus.EX_Mask     = ctrl_q.ex_mask;
    assign bus.MEM_Mask    = ctrl_q.mem_mask;
    assign bus.mem_timeout = timeout_q;
    assign bus.state       = state_q;

endmodule
